// File: rtl/rvga_membus_sram.sv
`default_nettype none
// ============================================================================
// Module   : rvga_membus_sram
// Purpose  : Block-RAM backed memory-bus responder for one membus port
//            (imem or dmem). Accepts a read or write request, waits a
//            programmable latency, then acknowledges BURST_LEN beats with
//            critical-word-first wrapping inside the burst-aligned block.
// Options  : `define RVGA_MEMBUS_ERR_EN adds the sticky err_o output that
//            flags read+write collisions and out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module rvga_membus_sram #(
  parameter int    ADDR_W      = 32,
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LATENCY     = 4,
  parameter int    BURST_LEN   = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wmask_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  resp_o,
  output logic                  busy_o
`ifdef RVGA_MEMBUS_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LAT_W = $clog2(LATENCY);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0] BLK_MASK = IDX_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic [IDX_W-1:0]   base_q,  base_d;
  logic [LAT_W-1:0]   lat_q,   lat_d;
  logic [CNT_W-1:0]   beat_q,  beat_d;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

  logic [ADDR_W-1:0]  w_addr_sh;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_accept;
  logic               w_last;
  logic [CNT_W-1:0]   w_rd_beat;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic               w_rd_en;
  logic               w_wr_en;

  // Beat n of a burst wraps inside the BURST_LEN-aligned block of words.
  function automatic logic [IDX_W-1:0] beat_idx(input logic [IDX_W-1:0] base,
                                                input logic [CNT_W-1:0] n);
    beat_idx = (base & ~BLK_MASK) | ((base + IDX_W'(n)) & BLK_MASK);
  endfunction

  // Byte offset dropped; address bits above the RAM range alias.
  assign w_addr_sh = addr_i >> OFF_W;
  assign w_req_idx = w_addr_sh[IDX_W-1:0];
  assign w_accept  = (state_q == IDLE) && (read_i || write_i);
  assign w_last    = (beat_q == CNT_W'(BURST_LEN - 1));

  // RAM read is issued one cycle ahead of the beat it serves.
  assign w_rd_beat = (state_q == BEAT) ? beat_q + CNT_W'(1) : '0;
  assign w_rd_idx  = beat_idx(base_q, w_rd_beat);
  assign w_rd_en   = (state_d == BEAT) && !op_wr_q;
  assign w_wr_idx  = beat_idx(base_q, beat_q);
  assign w_wr_en   = (state_q == BEAT) && op_wr_q;

  assign resp_o  = (state_q == BEAT);
  assign busy_o  = (state_q != IDLE);
  assign rdata_o = rdata_q;

  // Upper shifted-address bits only matter for range checking.
  logic w_unused_addr;
  assign w_unused_addr = ^w_addr_sh;

  // Control state and request context registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      base_q  <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic: accept, count down latency, then stream the beats.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    base_d  = base_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (read_i || write_i) begin
          op_wr_d = write_i;  // simultaneous read+write is a write
          base_d  = w_req_idx;
          lat_d   = LAT_W'(LATENCY - 1);
          beat_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = BEAT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      BEAT: begin
        if (w_last) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-masked RAM write on every write beat; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wmask_i[k]) begin
          mem_q[w_wr_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Registered read data; holds its value between read beats.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (w_rd_en) begin
      rdata_q <= mem_q[w_rd_idx];
    end
  end

`ifdef RVGA_MEMBUS_ERR_EN
  logic [ADDR_W-1:0] w_addr_hi;
  logic              w_err_hit;
  logic              err_q;

  assign w_addr_hi = addr_i >> (IDX_W + OFF_W);
  assign w_err_hit = w_accept && ((read_i && write_i) || (w_addr_hi != '0));
  assign err_o     = err_q;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (w_err_hit) begin
      err_q <= 1'b1;
      $error("rvga_membus_sram: bad request at address 0x%0h", addr_i);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvga_membus_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvga_membus_sram
// Purpose  : Directed test of rvga_membus_sram with a single-beat and a
//            four-beat instance (LATENCY=4). Honours RVGA_MEMBUS_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvga_membus_sram;

  logic        clk;
  logic        rst_n;
  logic        rd1, wr1, rd4, wr4;
  logic [31:0] addr_b;
  logic [31:0] wdata_b;
  logic [3:0]  wmask_b;
  logic [31:0] rdata1, rdata4;
  logic        resp1, resp4, busy1, busy4;
`ifdef RVGA_MEMBUS_ERR_EN
  logic        err1, err4;
`endif

  logic        sel;
  logic        resp_s, busy_s;
  logic [31:0] rdata_s;

  int          n_chk;
  int          n_fail;
  int          t_lat, t_busy, t_nb, cnt;
  logic [31:0] t_wd [4];
  logic [31:0] t_rd [8];

  assign resp_s  = sel ? resp4  : resp1;
  assign busy_s  = sel ? busy4  : busy1;
  assign rdata_s = sel ? rdata4 : rdata1;

  rvga_membus_sram #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(4096), .LATENCY(4), .BURST_LEN(1), .INIT_FILE("")
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .read_i(rd1), .write_i(wr1), .addr_i(addr_b),
    .wdata_i(wdata_b), .wmask_i(wmask_b), .rdata_o(rdata1), .resp_o(resp1), .busy_o(busy1)
`ifdef RVGA_MEMBUS_ERR_EN
    , .err_o(err1)
`endif
  );

  rvga_membus_sram #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(4096), .LATENCY(4), .BURST_LEN(4), .INIT_FILE("")
  ) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .read_i(rd4), .write_i(wr4), .addr_i(addr_b),
    .wdata_i(wdata_b), .wmask_i(wmask_b), .rdata_o(rdata4), .resp_o(resp4), .busy_o(busy4)
`ifdef RVGA_MEMBUS_ERR_EN
    , .err_o(err4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit s, input bit rq, input bit wq);
    if (s) begin rd4 = rq; wr4 = wq; end
    else   begin rd1 = rq; wr1 = wq; end
  endtask

  // One complete transaction held per the initiator contract; called at a
  // negedge, returns at the negedge after the last beat.
  task automatic xfer(input bit s, input bit rq, input bit wq, input logic [31:0] addr,
                      input logic [3:0] wm, input int nexp);
    sel     = s;
    addr_b  = addr;
    wmask_b = wm;
    wdata_b = t_wd[0];
    set_req(s, rq, wq);
    t_lat = 0; t_busy = 0; t_nb = 0;
    @(posedge clk);
    @(negedge clk);
    while (!resp_s && t_lat < 40) begin
      if (busy_s) t_busy++;
      @(posedge clk);
      t_lat++;
      @(negedge clk);
    end
    while (resp_s && t_nb < 8) begin
      t_rd[t_nb] = rdata_s;
      t_nb++;
      @(posedge clk);
      #1;
      if (t_nb >= nexp) set_req(s, 1'b0, 1'b0);
      else              wdata_b = t_wd[t_nb];
      @(negedge clk);
    end
    set_req(s, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; rd1 = 0; wr1 = 0; rd4 = 0; wr4 = 0; sel = 0;
    addr_b = '0; wdata_b = '0; wmask_b = '0;
    t_wd = '{32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp1",  32'(resp1),  32'd0);
    chk("rst_busy1",  32'(busy1),  32'd0);
    chk("rst_rdata1", rdata1,      32'd0);
    chk("rst_resp4",  32'(resp4),  32'd0);
    chk("rst_busy4",  32'(busy4),  32'd0);
    chk("rst_rdata4", rdata4,      32'd0);
`ifdef RVGA_MEMBUS_ERR_EN
    chk("rst_err1",   32'(err1),   32'd0);
`endif

    // Single-beat write then read of 0x10
    t_wd[0] = 32'hDEADBEEF;
    xfer(0, 0, 1, 32'h10, 4'hF, 1);
    chk("wr_lat",  t_lat,  4);
    chk("wr_busy", t_busy, 4);
    chk("wr_nb",   t_nb,   1);
    xfer(0, 1, 0, 32'h10, 4'hF, 1);
    chk("rd_lat",   t_lat,   4);
    chk("rd_busy",  t_busy,  4);
    chk("rd_nb",    t_nb,    1);
    chk("rd_data",  t_rd[0], 32'hDEADBEEF);
    chk("idle_busy", 32'(busy1), 32'd0);

    // Read followed immediately by write: accepted one idle cycle later
    t_wd[0] = 32'h11223344;
    xfer(0, 0, 1, 32'h20, 4'hF, 1);
    chk("b2b_lat", t_lat, 4);
    chk("b2b_nb",  t_nb,  1);

    // Byte-masked write; read with nonzero byte offset
    t_wd[0] = 32'hAABBCCDD;
    xfer(0, 0, 1, 32'h20, 4'b0101, 1);
    xfer(0, 1, 0, 32'h23, 4'hF, 1);
    chk("mask_data", t_rd[0], 32'h11BB33DD);

    t_wd[0] = 32'h0000C0DE;
    xfer(0, 0, 1, 32'h0, 4'hF, 1);

    // read_i and write_i together behave as a write
    t_wd[0] = 32'h0BADF00D;
    xfer(0, 1, 1, 32'h30, 4'hF, 1);
    xfer(0, 1, 0, 32'h30, 4'hF, 1);
    chk("rw_data", t_rd[0], 32'h0BADF00D);
`ifdef RVGA_MEMBUS_ERR_EN
    chk("rw_err", 32'(err1), 32'd1);
`endif

    // Out-of-range address aliases onto word 0
    xfer(0, 1, 0, 32'h0001_0000, 4'hF, 1);
    chk("alias_data", t_rd[0], 32'h0000C0DE);
`ifdef RVGA_MEMBUS_ERR_EN
    chk("alias_err", 32'(err1), 32'd1);
`endif

    // Four-beat burst: fill words 8..11, read from word 10 (wrapping)
    t_wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    xfer(1, 0, 1, 32'h20, 4'hF, 4);
    chk("b4_wr_nb",  t_nb,  4);
    xfer(1, 1, 0, 32'h28, 4'hF, 4);
    chk("b4_lat",    t_lat,   4);
    chk("b4_busy",   t_busy,  4);
    chk("b4_nb",     t_nb,    4);
    chk("b4_beat0",  t_rd[0], 32'hA2);
    chk("b4_beat1",  t_rd[1], 32'hA3);
    chk("b4_beat2",  t_rd[2], 32'hA0);
    chk("b4_beat3",  t_rd[3], 32'hA1);

    // Reset during beat 2 of a four-beat write to words 16..19
    t_wd = '{32'h50000000, 32'h50000001, 32'h50000002, 32'h50000003};
    xfer(1, 0, 1, 32'h40, 4'hF, 4);
    t_wd = '{32'h60000000, 32'h60000001, 32'h60000002, 32'h60000003};
    sel = 1; addr_b = 32'h40; wmask_b = 4'hF; wdata_b = t_wd[0]; wr4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt = 0;
    while (!resp4 && cnt < 40) begin
      @(posedge clk); cnt++; @(negedge clk);
    end
    chk("mid_first_resp", 32'(resp4), 32'd1);
    @(posedge clk); #1; wdata_b = t_wd[1];
    @(negedge clk);
    @(posedge clk); #1; wdata_b = t_wd[2];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp",  32'(resp4), 32'd0);
    chk("mid_rst_busy",  32'(busy4), 32'd0);
    chk("mid_rst_rdata", rdata4,     32'd0);
`ifdef RVGA_MEMBUS_ERR_EN
    chk("mid_rst_err1",  32'(err1),  32'd0);
`endif
    wr4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 1, 0, 32'h40, 4'hF, 4);
    chk("post_rst_lat", t_lat,   4);
    chk("post_rst_nb",  t_nb,    4);
    chk("post_w16",     t_rd[0], 32'h60000000);
    chk("post_w17",     t_rd[1], 32'h60000001);
    chk("post_w18",     t_rd[2], 32'h50000002);
    chk("post_w19",     t_rd[3], 32'h50000003);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
